pipeline_ex_stage_md: RTL and testbench
=======================================

# pipeline_ex_stage_md

Parametrised execute stage for the 5-stage RISC-V pipeline, sitting between the ID stage and the MEM stage. It evaluates ALU and branch/jump operations in one cycle and registers the results into the EX/MEM pipeline register. It adds an XLEN-generic datapath and a valid/ready handshake with flush. It also adds an optional iterative multiply/divide unit (RV M extension) that holds the stage busy while it runs.

## Interface
- XLEN, 64, datapath width (32 or 64).
- RD_W, 5, register-address width.
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- stall  input  1  MEM stage cannot accept; EX/MEM register holds.
- flush  input  1  kills the instruction in EX (mispredict/trap); has priority over stall.
- valid_ID  input  1  ID stage presents an instruction.
- ready_ID  output  1  stage accepts this cycle (combinational).
- reg_data1_ID, reg_data2_ID, imm_ID, pc_ID  input  XLEN each  operands, immediate, PC.
- rd_ID  input  RD_W  destination register.
- rf_wr_en_ID / rf_wr_sel_ID  input  1 / 2  write-back controls, passed through.
- dm_rd_ctrl_ID / dm_wr_ctrl_ID  input  3 / 3  memory controls, passed through.
- alu_ctrl  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B; others give 0.
- alu_a_sel / alu_b_sel  input  1 / 1  A: 1=reg_data1, 0=pc; B: 1=imm, 0=reg_data2.
- is_branch / do_jump  input  1 / 1  control-transfer instruction / unconditional jump.
- BrType  input  3  funct3 encoding: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2/3 never taken.
- md_en_ID / md_op_ID  input  1 / 3  mul/div request; op is funct3 (0 MUL … 7 REMU).
- valid_EX  output  1  EX/MEM register holds a live instruction.
- pc_EX, alu_result_EX, reg_data2_EX, branch_target_EX  output  XLEN each  registered results.
- rd_EX, rf_wr_en_EX, rf_wr_sel_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX  output  as inputs  registered pass-through.
- branch_taken_EX  output  1  registered redirect request.
- md_busy  output  1  FSM not in IDLE.

## Operation
- Shift amount is B[5:0] for XLEN=64 and B[4:0] for XLEN=32. Arithmetic wraps modulo 2^XLEN.
- branch_taken = is_branch & (do_jump | BrE).
- branch_target = ((alu_a_sel ? reg_data1 : pc) + imm) with bit 0 cleared, so JALR is supported.
- When a transfer is not taken, branch_taken_EX=0 and branch_target_EX=0.
- A non-MD instruction is accepted when valid_ID & ready_ID and is captured at the next edge with valid_EX=1.
- If no instruction is accepted and stall=0, valid_EX←0. The EX/MEM register then captures the idle inputs: data outputs take whatever is on the inputs, and rf_wr_en_EX and dm_wr_ctrl_EX are forced to 0.
- MD FSM states:
  - IDLE: on an accepted md_en_ID, latch the operands and op, compute the sign fix-ups, go to BUSY.
  - BUSY: one shift-add or restoring-divide step per cycle for XLEN cycles, then go to DONE.
  - DONE: write the result into alu_result_EX with valid_EX=1 and the pass-through fields, then go to IDLE. If stall=1, remain in DONE.
- MD result rules:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (MIN / −1): quotient = MIN, remainder = 0.
  - MULH/MULHSU/MULHU return the upper XLEN bits; MUL returns the lower XLEN bits.
- ready_ID = ~stall & (state==IDLE). It is 1 during flush.

## Timing
- Reset (async, low): every output 0, including valid_EX, branch_taken_EX and md_busy; FSM goes to IDLE.
- ALU/branch latency: 1 cycle (accept edge → outputs valid).
- MD latency:
  - Accept edge enters BUSY.
  - XLEN BUSY cycles follow.
  - Result is registered at edge XLEN+2 after acceptance.
  - md_busy and ~ready_ID hold from the accept edge until the DONE write.
- stall=1: all EX outputs hold and no instruction is accepted. The MD iteration continues but the FSM parks in DONE.
- flush=1 at an edge:
  - valid_EX←0, branch_taken_EX←0, rf_wr_en_EX←0, dm_wr_ctrl_EX←0.
  - FSM→IDLE and any MD operation is aborted.
  - The ID instruction presented in that cycle is discarded.
- Simultaneous stall and flush: flush wins.

## Configuration
- Macro `RV_M_EXT_EN`.
- Defined: the MD FSM and datapath are compiled in, with behaviour as above.
- Undefined: the MD logic is absent, md_busy is tied to 0, ready_ID = ~stall, and md_en_ID is ignored (the instruction executes as its alu_ctrl op).

## Test plan
- ADD, XLEN=64: reg1=5, imm=7, alu_b_sel=1 → after 1 cycle, alu_result_EX=12, valid_EX=1.
- BLT (BrType=4): reg1=−1, reg2=1, pc=0x100, imm=0x20 → branch_taken_EX=1, branch_target_EX=0x120. Same setup with BLTU (BrType=6) → branch_taken_EX=0.
- JALR: alu_a_sel=1, reg1=0x1001, imm=4, do_jump=1, is_branch=1 → branch_target_EX=0x1004.
- MD (`RV_M_EXT_EN` defined, XLEN=64):
  - DIV 7/0 → all-ones; REM 7/0 → 7.
  - DIV MIN/−1 → MIN.
  - MULHU all-ones × 2 → 1.
  - ready_ID=0 for the full latency; result at edge XLEN+2.
- Stall, flush and reset:
  - stall held 3 cycles → outputs unchanged.
  - flush during MD BUSY → valid_EX=0, md_busy=0 next cycle, ready_ID=1.
  - reset asserted mid-MD → all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_ex_stage_md.sv
// pipeline_ex_stage_md: RISC-V execute stage (ALU, branch resolve, EX/MEM register).
// Defining RV_M_EXT_EN adds an iterative multiply/divide unit that holds the stage busy.
module pipeline_ex_stage_md #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_ID,
    output logic            ready_ID,
    input  logic [XLEN-1:0] reg_data1_ID,
    input  logic [XLEN-1:0] reg_data2_ID,
    input  logic [XLEN-1:0] imm_ID,
    input  logic [XLEN-1:0] pc_ID,
    input  logic [RD_W-1:0] rd_ID,
    input  logic            rf_wr_en_ID,
    input  logic [1:0]      rf_wr_sel_ID,
    input  logic [2:0]      dm_rd_ctrl_ID,
    input  logic [2:0]      dm_wr_ctrl_ID,
    input  logic [3:0]      alu_ctrl,
    input  logic            alu_a_sel,
    input  logic            alu_b_sel,
    input  logic            is_branch,
    input  logic            do_jump,
    input  logic [2:0]      BrType,
    input  logic            md_en_ID,
    input  logic [2:0]      md_op_ID,
    output logic            valid_EX,
    output logic [XLEN-1:0] pc_EX,
    output logic [XLEN-1:0] alu_result_EX,
    output logic [XLEN-1:0] reg_data2_EX,
    output logic [XLEN-1:0] branch_target_EX,
    output logic [RD_W-1:0] rd_EX,
    output logic            rf_wr_en_EX,
    output logic [1:0]      rf_wr_sel_EX,
    output logic [2:0]      dm_rd_ctrl_EX,
    output logic [2:0]      dm_wr_ctrl_EX,
    output logic            branch_taken_EX,
    output logic            md_busy
);
    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] op_a, op_b, alu_res, br_tgt;
    logic [SH_W-1:0] shamt;
    logic            br_e, br_taken, acc_alu, md_req;

    logic            valid_q, taken_q, wen_q;
    logic [XLEN-1:0] pc_q, alu_q, rs2_q, tgt_q;
    logic [RD_W-1:0] rd_q;
    logic [1:0]      wsel_q;
    logic [2:0]      dmr_q, dmw_q;

    assign op_a   = alu_a_sel ? reg_data1_ID : pc_ID;
    assign op_b   = alu_b_sel ? imm_ID : reg_data2_ID;
    assign shamt  = op_b[SH_W-1:0];
    assign br_tgt = (op_a + imm_ID) & ~XLEN'(1);

    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
            4'd4:    alu_res = XLEN'(op_a < op_b);
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (BrType)
            3'd0:    br_e = reg_data1_ID == reg_data2_ID;
            3'd1:    br_e = reg_data1_ID != reg_data2_ID;
            3'd4:    br_e = $signed(reg_data1_ID) < $signed(reg_data2_ID);
            3'd5:    br_e = $signed(reg_data1_ID) >= $signed(reg_data2_ID);
            3'd6:    br_e = reg_data1_ID < reg_data2_ID;
            3'd7:    br_e = reg_data1_ID >= reg_data2_ID;
            default: br_e = 1'b0;
        endcase
    end

    assign br_taken = is_branch & (do_jump | br_e);
    assign ready_ID = ~stall & ~md_busy;
    assign acc_alu  = valid_ID & ready_ID & ~md_req;

`ifdef RV_M_EXT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    md_state_e       state_q, state_d;
    logic [XLEN-1:0] hi_q, lo_q, b_q, hi_d, lo_d, a_abs, b_abs, div_v, md_res;
    logic [XLEN-1:0] md_pc_q, md_rs2_q;
    logic [RD_W-1:0] md_rd_q;
    logic [1:0]      md_wsel_q;
    logic [2:0]      op_q, md_dmr_q, md_dmw_q;
    logic [SH_W-1:0] cnt_q;
    logic [XLEN:0]   mul_sum, div_r;
    logic [2*XLEN-1:0] prod;
    logic            neg_q, md_wen_q, a_neg, b_neg, neg_d, md_acc, div_ge, is_mul;

    assign md_req  = md_en_ID;
    assign md_busy = state_q != IDLE;
    assign md_acc  = valid_ID & ready_ID & md_en_ID & ~flush;
    // Operands run unsigned through the iteration; signs are re-applied to the result.
    assign a_neg   = reg_data1_ID[XLEN-1] & (md_op_ID == 3'd1 | md_op_ID == 3'd2 | md_op_ID == 3'd4 | md_op_ID == 3'd6);
    assign b_neg   = reg_data2_ID[XLEN-1] & (md_op_ID == 3'd1 | md_op_ID == 3'd4 | md_op_ID == 3'd6);
    assign a_abs   = a_neg ? -reg_data1_ID : reg_data1_ID;
    assign b_abs   = b_neg ? -reg_data2_ID : reg_data2_ID;
    // A zero divisor keeps the all-ones quotient unsigned; the remainder still regains the dividend's sign.
    assign neg_d   = md_op_ID[2] ? (md_op_ID[1] ? a_neg : (a_neg ^ b_neg) & |reg_data2_ID) : a_neg ^ b_neg;
    assign is_mul  = ~op_q[2];
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_r   = {hi_q, lo_q[XLEN-1]};
    assign div_ge  = div_r >= {1'b0, b_q};
    assign hi_d    = is_mul ? mul_sum[XLEN:1] : div_ge ? div_r[XLEN-1:0] - b_q : div_r[XLEN-1:0];
    assign lo_d    = is_mul ? {mul_sum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], div_ge};
    assign prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign div_v   = op_q[1] ? hi_q : lo_q;
    assign md_res  = !is_mul ? (neg_q ? -div_v : div_v) : op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = md_acc ? BUSY : IDLE;
            BUSY:    state_d = cnt_q == SH_W'(XLEN - 1) ? DONE : BUSY;
            DONE:    state_d = stall ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            md_pc_q   <= '0;
            md_rs2_q  <= '0;
            md_rd_q   <= '0;
            md_wen_q  <= 1'b0;
            md_wsel_q <= '0;
            md_dmr_q  <= '0;
            md_dmw_q  <= '0;
        end else begin
            state_q <= state_d;
            if (md_acc) begin
                hi_q      <= '0;
                lo_q      <= a_abs;
                b_q       <= b_abs;
                cnt_q     <= '0;
                op_q      <= md_op_ID;
                neg_q     <= neg_d;
                md_pc_q   <= pc_ID;
                md_rs2_q  <= reg_data2_ID;
                md_rd_q   <= rd_ID;
                md_wen_q  <= rf_wr_en_ID;
                md_wsel_q <= rf_wr_sel_ID;
                md_dmr_q  <= dm_rd_ctrl_ID;
                md_dmw_q  <= dm_wr_ctrl_ID;
            end else if (state_q == BUSY) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
`else
    assign md_req  = 1'b0;
    assign md_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            wen_q   <= 1'b0;
            pc_q    <= '0;
            alu_q   <= '0;
            rs2_q   <= '0;
            tgt_q   <= '0;
            rd_q    <= '0;
            wsel_q  <= '0;
            dmr_q   <= '0;
            dmw_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            wen_q   <= 1'b0;
            dmw_q   <= '0;
        end else if (!stall) begin
`ifdef RV_M_EXT_EN
            if (state_q == DONE) begin
                valid_q <= 1'b1;
                taken_q <= 1'b0;
                wen_q   <= md_wen_q;
                pc_q    <= md_pc_q;
                alu_q   <= md_res;
                rs2_q   <= md_rs2_q;
                tgt_q   <= '0;
                rd_q    <= md_rd_q;
                wsel_q  <= md_wsel_q;
                dmr_q   <= md_dmr_q;
                dmw_q   <= md_dmw_q;
            end else
`endif
            begin
                valid_q <= acc_alu;
                taken_q <= br_taken;
                wen_q   <= rf_wr_en_ID & acc_alu;
                pc_q    <= pc_ID;
                alu_q   <= alu_res;
                rs2_q   <= reg_data2_ID;
                tgt_q   <= br_taken ? br_tgt : '0;
                rd_q    <= rd_ID;
                wsel_q  <= rf_wr_sel_ID;
                dmr_q   <= dm_rd_ctrl_ID;
                dmw_q   <= acc_alu ? dm_wr_ctrl_ID : 3'd0;
            end
        end
    end

    assign valid_EX         = valid_q;
    assign branch_taken_EX  = taken_q;
    assign rf_wr_en_EX      = wen_q;
    assign pc_EX            = pc_q;
    assign alu_result_EX    = alu_q;
    assign reg_data2_EX     = rs2_q;
    assign branch_target_EX = tgt_q;
    assign rd_EX            = rd_q;
    assign rf_wr_sel_EX     = wsel_q;
    assign dm_rd_ctrl_EX    = dmr_q;
    assign dm_wr_ctrl_EX    = dmw_q;
endmodule

// File: tb/tb_pipeline_ex_stage_md.sv
// tb_pipeline_ex_stage_md: directed plus randomized checks of the EX stage against a behavioural model.
module tb_pipeline_ex_stage_md;
    localparam int XLEN = 64;
    localparam int RD_W = 5;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0, reset = 1'b0, stall = 1'b0, flush = 1'b0, valid_ID = 1'b0, ready_ID;
    logic [XLEN-1:0] reg_data1_ID = '0, reg_data2_ID = '0, imm_ID = '0, pc_ID = '0;
    logic [RD_W-1:0] rd_ID = '0;
    logic            rf_wr_en_ID = 1'b0;
    logic [1:0]      rf_wr_sel_ID = '0;
    logic [2:0]      dm_rd_ctrl_ID = '0, dm_wr_ctrl_ID = '0;
    logic [3:0]      alu_ctrl = '0;
    logic            alu_a_sel = 1'b0, alu_b_sel = 1'b0, is_branch = 1'b0, do_jump = 1'b0;
    logic [2:0]      BrType = '0;
    logic            md_en_ID = 1'b0;
    logic [2:0]      md_op_ID = '0;
    logic            valid_EX, rf_wr_en_EX, branch_taken_EX, md_busy;
    logic [XLEN-1:0] pc_EX, alu_result_EX, reg_data2_EX, branch_target_EX;
    logic [RD_W-1:0] rd_EX;
    logic [1:0]      rf_wr_sel_EX;
    logic [2:0]      dm_rd_ctrl_EX, dm_wr_ctrl_EX;

    pipeline_ex_stage_md #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_ID(valid_ID), .ready_ID(ready_ID),
        .reg_data1_ID(reg_data1_ID), .reg_data2_ID(reg_data2_ID), .imm_ID(imm_ID), .pc_ID(pc_ID),
        .rd_ID(rd_ID), .rf_wr_en_ID(rf_wr_en_ID), .rf_wr_sel_ID(rf_wr_sel_ID),
        .dm_rd_ctrl_ID(dm_rd_ctrl_ID), .dm_wr_ctrl_ID(dm_wr_ctrl_ID),
        .alu_ctrl(alu_ctrl), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .is_branch(is_branch), .do_jump(do_jump), .BrType(BrType),
        .md_en_ID(md_en_ID), .md_op_ID(md_op_ID),
        .valid_EX(valid_EX), .pc_EX(pc_EX), .alu_result_EX(alu_result_EX),
        .reg_data2_EX(reg_data2_EX), .branch_target_EX(branch_target_EX),
        .rd_EX(rd_EX), .rf_wr_en_EX(rf_wr_en_EX), .rf_wr_sel_EX(rf_wr_sel_EX),
        .dm_rd_ctrl_EX(dm_rd_ctrl_EX), .dm_wr_ctrl_EX(dm_wr_ctrl_EX),
        .branch_taken_EX(branch_taken_EX), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    logic            e_valid, e_taken, e_wen;
    logic [63:0]     e_alu, e_tgt, e_pc, e_rs2;
    logic [RD_W-1:0] e_rd;
    logic [1:0]      e_wsel;
    logic [2:0]      e_dmr, e_dmw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] alu_ref(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        longint sa = a, sb = b;
        int sh = int'(b[5:0]);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return (sa < sb) ? 64'd1 : 64'd0;
            4'd4: return (a < b) ? 64'd1 : 64'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return sa >>> sh;
            4'd8: return a | b;
            4'd9: return a & b;
            4'd10: return b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic br_ref(input logic isb, input logic j, input logic [2:0] t,
                                    input logic [63:0] r1, input logic [63:0] r2);
        longint s1 = r1, s2 = r2;
        logic c;
        case (t)
            3'd0: c = r1 == r2;
            3'd1: c = r1 != r2;
            3'd4: c = s1 < s2;
            3'd5: c = s1 >= s2;
            3'd6: c = r1 < r2;
            3'd7: c = r1 >= r2;
            default: c = 1'b0;
        endcase
        return isb & (j | c);
    endfunction

    function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        longint sa = a, sb = b;
        logic ovf = (a == MIN) && (b == '1);
        case (op)
            3'd0: return a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            3'd4: return (b == 0) ? '1 : ovf ? MIN : sa / sb;
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: return (b == 0) ? a : ovf ? 64'd0 : sa % sb;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic rand_instr();
        reg_data1_ID  = {$urandom, $urandom};
        reg_data2_ID  = ($urandom_range(0, 3) == 0) ? reg_data1_ID : {$urandom, $urandom};
        imm_ID        = {$urandom, $urandom};
        pc_ID         = {$urandom, $urandom};
        rd_ID         = RD_W'($urandom);
        rf_wr_en_ID   = 1'($urandom);
        rf_wr_sel_ID  = 2'($urandom);
        dm_rd_ctrl_ID = 3'($urandom);
        dm_wr_ctrl_ID = 3'($urandom_range(1, 7));
        alu_ctrl      = 4'($urandom);
        alu_a_sel     = 1'($urandom);
        alu_b_sel     = 1'($urandom);
        is_branch     = 1'($urandom);
        do_jump       = $urandom_range(0, 3) == 0;
        BrType        = 3'($urandom);
        md_en_ID      = 1'b0;
        md_op_ID      = 3'($urandom);
        valid_ID      = 1'b1;
    endtask

    // Expected EX/MEM contents one edge later, assuming no stall or flush at that edge.
    task automatic predict();
        logic [63:0] a = alu_a_sel ? reg_data1_ID : pc_ID;
        logic [63:0] b = alu_b_sel ? imm_ID : reg_data2_ID;
        e_valid = valid_ID;
        e_alu   = alu_ref(alu_ctrl, a, b);
        e_taken = br_ref(is_branch, do_jump, BrType, reg_data1_ID, reg_data2_ID);
        e_tgt   = e_taken ? ((a + imm_ID) & ~64'd1) : 64'd0;
        e_pc    = pc_ID;
        e_rs2   = reg_data2_ID;
        e_rd    = rd_ID;
        e_wen   = rf_wr_en_ID & valid_ID;
        e_wsel  = rf_wr_sel_ID;
        e_dmr   = dm_rd_ctrl_ID;
        e_dmw   = valid_ID ? dm_wr_ctrl_ID : 3'd0;
    endtask

    task automatic check_ex(input string tag, input logic with_br);
        chk({tag, ".valid"}, valid_EX, e_valid);
        chk({tag, ".alu"}, alu_result_EX, e_alu);
        chk({tag, ".pc"}, pc_EX, e_pc);
        chk({tag, ".rs2"}, reg_data2_EX, e_rs2);
        chk({tag, ".rd"}, rd_EX, e_rd);
        chk({tag, ".wen"}, rf_wr_en_EX, e_wen);
        chk({tag, ".wsel"}, rf_wr_sel_EX, e_wsel);
        chk({tag, ".dmr"}, dm_rd_ctrl_EX, e_dmr);
        chk({tag, ".dmw"}, dm_wr_ctrl_EX, e_dmw);
        if (with_br) begin
            chk({tag, ".taken"}, branch_taken_EX, e_taken);
            chk({tag, ".tgt"}, branch_target_EX, e_tgt);
        end
    endtask

    task automatic md_start(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        rand_instr();
        md_en_ID = 1'b1;
        md_op_ID = op;
        reg_data1_ID = a;
        reg_data2_ID = b;
        rf_wr_en_ID = 1'b1;
    endtask

    task automatic md_run(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n = 1;
        logic busy_ok = 1'b1;
        logic [63:0] md_e = md_ref(op, a, b);
        logic [63:0] pc0;
        logic [RD_W-1:0] rd0;
        md_start(op, a, b);
        pc0 = pc_ID;
        rd0 = rd_ID;
        step();
        rand_instr();
        valid_ID = 1'b0;
        rd_ID = ~rd0;
        while (valid_EX !== 1'b1 && n < 200) begin
            busy_ok &= (ready_ID === 1'b0) && (md_busy === 1'b1);
            step();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(XLEN + 2));
        chk({tag, ".busy_hold"}, busy_ok, 1'b1);
        chk({tag, ".result"}, alu_result_EX, md_e);
        chk({tag, ".rd"}, rd_EX, rd0);
        chk({tag, ".pc"}, pc_EX, pc0);
        chk({tag, ".wen"}, rf_wr_en_EX, 1'b1);
        chk({tag, ".idle_after"}, md_busy, 1'b0);
    endtask

    initial begin
        #12;
        chk("rst.valid", valid_EX, 1'b0);
        chk("rst.alu", alu_result_EX, 64'd0);
        chk("rst.taken", branch_taken_EX, 1'b0);
        chk("rst.busy", md_busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();

        valid_ID = 1'b1; alu_ctrl = 4'd0; alu_a_sel = 1'b1; alu_b_sel = 1'b1;
        reg_data1_ID = 64'd5; imm_ID = 64'd7;
        step();
        chk("add.result", alu_result_EX, 64'd12);
        chk("add.valid", valid_EX, 1'b1);

        alu_a_sel = 1'b0; is_branch = 1'b1; BrType = 3'd4;
        reg_data1_ID = '1; reg_data2_ID = 64'd1; pc_ID = 64'h100; imm_ID = 64'h20;
        step();
        chk("blt.taken", branch_taken_EX, 1'b1);
        chk("blt.target", branch_target_EX, 64'h120);
        BrType = 3'd6;
        step();
        chk("bltu.taken", branch_taken_EX, 1'b0);
        chk("bltu.target", branch_target_EX, 64'd0);

        alu_a_sel = 1'b1; reg_data1_ID = 64'h1001; imm_ID = 64'd4; do_jump = 1'b1; BrType = 3'd2;
        step();
        chk("jalr.taken", branch_taken_EX, 1'b1);
        chk("jalr.target", branch_target_EX, 64'h1004);

        for (int i = 0; i < 150; i++) begin
            rand_instr();
            valid_ID = $urandom_range(0, 4) != 0;
            predict();
            step();
            check_ex("rand", valid_ID);
        end

        rand_instr();
        predict();
        step();
        check_ex("pre_stall", 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_instr();
            #1;
            chk("stall.ready", ready_ID, 1'b0);
            step();
            check_ex("stall.hold", 1'b1);
        end
        stall = 1'b0;

        rand_instr();
        flush = 1'b1;
        #1;
        chk("flush.ready", ready_ID, 1'b1);
        step();
        flush = 1'b0;
        chk("flush.valid", valid_EX, 1'b0);
        chk("flush.wen", rf_wr_en_EX, 1'b0);
        chk("flush.dmw", dm_wr_ctrl_EX, 3'd0);
        chk("flush.taken", branch_taken_EX, 1'b0);

        rand_instr();
        predict();
        step();
        check_ex("pre_flush_stall", 1'b1);
        rand_instr();
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        chk("flush_stall.valid", valid_EX, 1'b0);
        chk("flush_stall.wen", rf_wr_en_EX, 1'b0);

`ifdef RV_M_EXT_EN
        md_run("div0", 3'd4, 64'd7, 64'd0);
        md_run("rem0", 3'd6, 64'd7, 64'd0);
        md_run("divovf", 3'd4, MIN, '1);
        md_run("mulhu", 3'd3, '1, 64'd2);
        for (int i = 0; i < 8; i++)
            md_run("md_rand", 3'(i), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom});

        md_start(3'd5, 64'd1000, 64'd7);
        step();
        valid_ID = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("md_flush.valid", valid_EX, 1'b0);
        chk("md_flush.busy", md_busy, 1'b0);
        chk("md_flush.ready", ready_ID, 1'b1);

        md_start(3'd0, 64'd123, 64'd456);
        step();
        valid_ID = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        #1;
        chk("md_rst.busy", md_busy, 1'b0);
`else
        rand_instr();
        md_en_ID = 1'b1;
        predict();
        step();
        check_ex("md_ignored", 1'b1);
        chk("md_ignored.busy", md_busy, 1'b0);
        rand_instr();
        step();
        reset = 1'b0;
        #1;
`endif
        chk("mid_rst.valid", valid_EX, 1'b0);
        chk("mid_rst.alu", alu_result_EX, 64'd0);
        chk("mid_rst.pc", pc_EX, 64'd0);
        chk("mid_rst.rd", rd_EX, 5'd0);
        chk("mid_rst.taken", branch_taken_EX, 1'b0);
        chk("mid_rst.tgt", branch_target_EX, 64'd0);
        chk("mid_rst.wen", rf_wr_en_EX, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
